// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: front end for a SHA-256 compression core.
// Takes a message as 32-bit big-endian words, applies the standard padding
// (0x80, zero fill, 64-bit bit length) and builds 512-bit blocks. It starts
// the core on each block and chains the digest the core returns into the
// next block. The final digest is presented on hash_out together with a
// one-cycle done pulse.
// Optional build macro SHA256_PADDER_IV_LOAD_EN: adds iv_in/iv_bytes so that
// a message can resume from a precomputed chaining state and byte count.
module sha256_msg_padder #(
  parameter int unsigned  LEN_W    = 64,
  parameter logic [255:0] IV_CONST = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         core_start,
  output logic [511:0] core_message,
  output logic [255:0] core_digest,
  input  logic [255:0] core_result,
  input  logic         core_valid,
  output logic [255:0] hash_out,
  output logic         done
`ifdef SHA256_PADDER_IV_LOAD_EN
  ,
  input  logic [255:0] iv_in,
  input  logic [63:0]  iv_bytes
`endif
);

  typedef enum logic [2:0] {
    S_FILL, S_PAD, S_ISSUE, S_WAIT, S_LENBLK, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [4:0]       idx;         // next word slot in the current block
  logic [LEN_W-1:0] byte_cnt;    // message bytes accepted so far
  logic [2:0]       last_nb;     // effective byte count of the latest word
  logic             more;        // block filled with message still running
  logic             final_blk;   // block in flight carries the length
  logic             pend_80;     // 0x80 marker deferred to the length block
  logic             first_word;  // next accepted word opens a new message

  logic             accept;
  logic [2:0]       nb_eff;
  logic [31:0]      in_masked;
  logic [LEN_W-1:0] cnt_base;
  logic [63:0]      bit_len;
  logic [4:0]       last_slot;
  logic [4:0]       mark_slot;
  logic [31:0]      last_word;
  logic [31:0]      mark_word;

  assign accept    = in_valid && in_ready;
  // Non-final words always count as four bytes; oversized counts clamp to four.
  assign nb_eff    = (!in_last || in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  // Bytes past the valid count are cleared so padding can OR in the marker.
  assign in_masked = in_data & ~(32'hffff_ffff >> {nb_eff, 3'b000});

`ifdef SHA256_PADDER_IV_LOAD_EN
  // A resumed message continues from a whole number of 64-byte blocks.
  assign cnt_base  = first_word ? LEN_W'({iv_bytes[63:6], 6'b000000}) : byte_cnt;
`else
  assign cnt_base  = first_word ? '0 : byte_cnt;
`endif

  assign bit_len   = 64'({byte_cnt, 3'b000});
  assign last_slot = idx - 5'd1;
  // A full last word pushes the marker into the following slot (16 = next block).
  assign mark_slot = (last_nb == 3'd4) ? idx : last_slot;
  assign last_word = core_message[{4'd15 - last_slot[3:0], 5'b00000} +: 32];
  assign mark_word = last_word | (32'h8000_0000 >> {last_nb, 3'b000});

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (RST) state <= S_FILL;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    case (state)
      S_FILL:   if (accept) begin
                  if (in_last)             state_nxt = S_PAD;
                  else if (idx == 5'd15)   state_nxt = S_ISSUE;
                end
      S_PAD:    state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   if (core_valid) begin
                  if (more)                state_nxt = S_FILL;
                  else if (!final_blk)     state_nxt = S_LENBLK;
                  else                     state_nxt = S_DONE;
                end
      S_LENBLK: state_nxt = S_ISSUE;
      S_DONE:   state_nxt = S_FILL;
      default:  state_nxt = S_FILL;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    done       = 1'b0;
    case (state)
      S_FILL:  in_ready   = 1'b1;
      S_ISSUE: core_start = 1'b1;
      S_DONE:  done       = 1'b1;
      default: ;
    endcase
  end

  // Block assembly, padding, digest chaining and byte counting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the block buffer is a plain register with a defined reset value,
      // not a RAM, so clearing it here is intended.
      core_message <= '0;
      core_digest  <= IV_CONST;
      hash_out     <= '0;
      idx          <= '0;
      byte_cnt     <= '0;
      last_nb      <= '0;
      more         <= 1'b0;
      final_blk    <= 1'b0;
      pend_80      <= 1'b0;
      first_word   <= 1'b1;
    end else begin
      case (state)
        S_FILL: if (accept) begin
          core_message[{4'd15 - idx[3:0], 5'b00000} +: 32] <= in_masked;
          idx        <= idx + 5'd1;
          byte_cnt   <= cnt_base + LEN_W'(nb_eff);
          last_nb    <= nb_eff;
          first_word <= 1'b0;
          more       <= !in_last && (idx == 5'd15);
`ifdef SHA256_PADDER_IV_LOAD_EN
          if (first_word) core_digest <= iv_in;
`endif
        end
        S_PAD: begin
          for (int i = 0; i < 16; i++)
            if (5'(i) > mark_slot) core_message[(15 - i) * 32 +: 32] <= '0;
          if (last_nb != 3'd4)
            core_message[{4'd15 - last_slot[3:0], 5'b00000} +: 32] <= mark_word;
          else if (idx != 5'd16)
            core_message[{4'd15 - idx[3:0], 5'b00000} +: 32] <= 32'h8000_0000;
          pend_80 <= (mark_slot == 5'd16);
          if (mark_slot <= 5'd13) begin
            core_message[63:0] <= bit_len;
            final_blk          <= 1'b1;
          end else begin
            final_blk          <= 1'b0;
          end
        end
        S_WAIT: if (core_valid) begin
          core_digest <= core_result;
          if (more) begin
            idx  <= '0;
            more <= 1'b0;
          end else if (final_blk) begin
            // Loaded here so hash_out is already valid while done is high.
            hash_out <= core_result;
          end
        end
        S_LENBLK: begin
          core_message <= {pend_80 ? 32'h8000_0000 : 32'h0, 416'b0, bit_len};
          final_blk    <= 1'b1;
          pend_80      <= 1'b0;
        end
        S_DONE: begin
          core_digest <= IV_CONST;
          idx         <= '0;
          byte_cnt    <= '0;
          last_nb     <= '0;
          final_blk   <= 1'b0;
          pend_80     <= 1'b0;
          first_word  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: a behavioural SHA-256 compression core answers
// core_start; a reference padding/hash model queues expected blocks, chaining
// values and final hashes, which are popped as the DUT produces them.
module tb_sha256_msg_padder;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] KAT_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] KAT_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] KAT_448   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_nbytes = '0;
  logic         core_start;
  logic [511:0] core_message;
  logic [255:0] core_digest;
  logic [255:0] core_result = '0;
  logic         core_valid = 1'b0;
  logic [255:0] hash_out;
  logic         done;
`ifdef SHA256_PADDER_IV_LOAD_EN
  logic [255:0] iv_in = IV;
  logic [63:0]  iv_bytes = '0;
`endif

  sha256_msg_padder dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_nbytes    (in_nbytes),
    .core_start   (core_start),
    .core_message (core_message),
    .core_digest  (core_digest),
    .core_result  (core_result),
    .core_valid   (core_valid),
    .hash_out     (hash_out),
    .done         (done)
`ifdef SHA256_PADDER_IV_LOAD_EN
    ,
    .iv_in        (iv_in),
    .iv_bytes     (iv_bytes)
`endif
  );

  always #5 CLK = ~CLK;

  logic [511:0] exp_blk [$];
  logic [255:0] exp_dig [$];
  logic [255:0] exp_hash [$];
  logic [7:0]   msg_q [$];

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int core_lat = 0;     // 0 selects a random 1..3 cycle core latency
  int pend_cnt = 0;
  logic [255:0] pend_res = '0;
  bit busy = 1'b0;
  bit prev_cv = 1'b0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, bb, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + bb, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Standard padding of msg_q; queues every block, its chaining input and the hash.
  task automatic build_expected(input logic [255:0] iv, input longint unsigned prefix,
                                input bit use_kat, input logic [255:0] kat);
    logic [7:0]   p [$];
    logic [63:0]  bits;
    logic [255:0] h;
    logic [511:0] blk;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = (prefix + longint'(msg_q.size())) * 8;
    for (int i = 0; i < 8; i++) p.push_back(bits[63 - 8 * i -: 8]);
    h = iv;
    for (int k = 0; k < p.size() / 64; k++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8 * j -: 8] = p[64 * k + j];
      exp_blk.push_back(blk);
      exp_dig.push_back(h);
      h = sha_compress(h, blk);
    end
    exp_hash.push_back(use_kat ? kat : h);
  endtask

  // Drives msg_q as words; unused bytes carry filler the DUT must discard.
  task automatic send_msg(input bit gaps, input bit odd_nb);
    int n, nw, nb, t;
    logic [31:0] word;
    bit last;
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      word = 32'ha5a5_a5a5;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < n) word[31 - 8 * b -: 8] = msg_q[4 * w + b];
      last = (w == nw - 1);
      nb = last ? n - 4 * w : 4;
      if (odd_nb) nb = last ? ((nb == 4) ? 7 : nb) : int'($urandom_range(3, 0));
      if (gaps) repeat ($urandom_range(2, 0)) @(negedge CLK);
      in_valid = 1'b1; in_data = word; in_last = last; in_nbytes = 3'(nb);
      t = 0;
      while (!in_ready && t < 500) begin @(negedge CLK); t++; end
      check("rdy_to", in_ready, 1);
      @(negedge CLK);
      in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_nbytes = '0;
    end
  endtask

  task automatic wait_done();
    int start, t;
    start = done_cnt;
    t = 0;
    while (done_cnt == start && t < 3000) begin @(negedge CLK); t++; end
    check("done_to", done_cnt != start, 1);
  endtask

  task automatic run_msg(input bit gaps, input bit odd_nb, input bit use_kat, input logic [255:0] kat,
                         input logic [255:0] iv, input longint unsigned prefix);
    build_expected(iv, prefix, use_kat, kat);
    send_msg(gaps, odd_nb);
    wait_done();
  endtask

  // Core stand-in plus done/hash and busy-ready monitors, all on the falling edge.
  initial begin
    bit cv;
    forever begin
      @(negedge CLK);
      if (done) begin
        done_cnt++;
        check("done_lat", prev_cv, 1);
        check("hash_q", exp_hash.size() > 0, 1);
        if (exp_hash.size() > 0) check("hash", hash_out, exp_hash.pop_front());
      end
      if (busy) check("rdy_busy", in_ready, 0);
      cv = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          cv = 1'b1;
          core_result = pend_res;
          busy = 1'b0;
        end
      end
      core_valid = cv;
      if (core_start) begin
        check("blk_q", exp_blk.size() > 0, 1);
        if (exp_blk.size() > 0) begin
          check("blk", core_message, exp_blk.pop_front());
          check("dig", core_digest, exp_dig.pop_front());
        end
        pend_res = sha_compress(core_digest, core_message);
        pend_cnt = (core_lat > 0) ? core_lat : int'($urandom_range(3, 1));
        busy = 1'b1;
      end
      prev_cv = cv;
    end
  end

  initial begin
    int lens [9] = '{55, 56, 57, 60, 63, 64, 65, 119, 128};
    int t, saved;
`ifdef SHA256_PADDER_IV_LOAD_EN
    logic [255:0] h1;
`endif

    repeat (3) @(negedge CLK);
    check("rst_ready", in_ready, 1);
    check("rst_start", core_start, 0);
    check("rst_done", done, 0);
    check("rst_msg", core_message, 0);
    check("rst_hash", hash_out, 0);
    check("rst_dig", core_digest, IV);
    RST = 1'b0;
    @(negedge CLK);

    // "abc"
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, 1'b0, 1'b1, KAT_ABC, IV, 0);

    // empty message
    msg_q.delete();
    run_msg(1'b0, 1'b0, 1'b1, KAT_EMPTY, IV, 0);

    // 56-byte message: marker and length split over two blocks
    msg_q.delete();
    for (int i = 0; i < 14; i++)
      for (int j = 0; j < 4; j++) msg_q.push_back(8'(8'h61 + i + j));
    run_msg(1'b0, 1'b0, 1'b1, KAT_448, IV, 0);

    // 64-byte message, steady then with random in_valid gaps
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'(i * 7 + 3));
    run_msg(1'b0, 1'b0, 1'b0, '0, IV, 0);
    run_msg(1'b1, 1'b0, 1'b0, '0, IV, 0);

    // lengths around every block boundary, gaps, odd non-final byte counts
    for (int k = 0; k < 9; k++) begin
      msg_q.delete();
      for (int i = 0; i < lens[k]; i++) msg_q.push_back(8'($urandom));
      run_msg(1'b1, k[0], 1'b0, '0, IV, 0);
    end

    // reset while waiting on the core; the late core_valid must be ignored
    core_lat = 12;
    msg_q = '{8'h61, 8'h62, 8'h63};
    build_expected(IV, 0, 1'b1, KAT_ABC);
    send_msg(1'b0, 1'b0);
    t = 0;
    while (!busy && t < 100) begin @(negedge CLK); t++; end
    check("issue_to", busy, 1);
    repeat (2) @(negedge CLK);
    saved = done_cnt;
    RST = 1'b1;
    busy = 1'b0;
    exp_blk.delete(); exp_dig.delete(); exp_hash.delete();
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    check("rst_nodone", done_cnt, saved);
    check("rst2_ready", in_ready, 1);
    check("rst2_dig", core_digest, IV);
    check("rst2_hash", hash_out, 0);
    check("rst2_msg", core_message, 0);
    core_lat = 0;
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, 1'b0, 1'b1, KAT_ABC, IV, 0);

`ifdef SHA256_PADDER_IV_LOAD_EN
    // explicit standard IV behaves like the default start
    iv_in = IV; iv_bytes = '0;
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, 1'b0, 1'b1, KAT_ABC, IV, 0);
    // resume after 64 bytes of 'a'; low bits of iv_bytes are dropped
    h1 = sha_compress(IV, {64{8'h61}});
    iv_in = h1; iv_bytes = 64'd77;
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'h61);
    run_msg(1'b1, 1'b0, 1'b0, '0, h1, 64);
    iv_in = IV; iv_bytes = '0;
`endif

    repeat (5) @(negedge CLK);
    check("q_empty", exp_blk.size() + exp_hash.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
